fp_align_shift: RTL and testbench
=================================

Name: fp_align_shift

Overview:
- Alignment stage of the vector FP adder, directly downstream of the significand swap stage.
- Takes the larger significand (A), the smaller significand (B) and the exponent difference.
- Right-shifts B into a 27-bit field {24-bit significand, guard, round, sticky}; A and sideband fields pass through unchanged.
- Two-stage pipeline with valid/ready handshake on both sides; full backpressure support.

Parameters:
- TAG_W, 4, width of the opaque tag (lane/op id) carried alongside each operation.
- EXP_W, 8, width of the exponent difference and exponent fields.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  input operation valid
- in_ready_o  out  1  stage can accept an input this cycle
- sig_a_i  in  24  larger significand, hidden bit included
- sig_b_i  in  24  smaller significand, hidden bit included
- exp_diff_i  in  EXP_W  unsigned shift amount for B
- exp_i  in  EXP_W  exponent of the larger operand (passthrough)
- tag_i  in  TAG_W  opaque tag (passthrough)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts the result
- sig_a_o  out  24  A, unchanged
- sig_b_o  out  27  aligned B {sig[26:3], guard, round, sticky}
- exp_o  out  EXP_W  exponent passthrough
- tag_o  out  TAG_W  tag passthrough

Behaviour:
- Reset: s1_valid, s2_valid, and therefore out_valid_o, go to 0; all data registers go to 0. Outputs read 0 after reset.
- Transfers:
  - Input transfer occurs on in_valid_i && in_ready_o.
  - Output transfer occurs on out_valid_o && out_ready_i.
- Pipeline:
  - Stage 1 register s1, stage 2 register s2; out_* are driven from s2.
  - s2 loads when (!s2_valid || out_ready_i).
  - s1 advances into s2 under the same condition.
  - in_ready_o = !s1_valid || s2 loads this cycle. This is combinational from out_ready_i; no combinational path from in_valid_i to in_ready_o.
- Latency: 2 cycles from input transfer to out_valid_o with no stall; throughput 1 op/cycle.
- Arithmetic:
  - Define ext = {sig_b_i, 3'b000} (27 bits) and d = exp_diff_i.
  - Stage 1 (coarse):
    - If d >= 32 (any bit above bit 4 set): saturate. Field becomes 0; sticky_partial = |sig_b_i.
    - Otherwise shift ext right by {d[4:3],3'b000}. sticky_partial = OR of all bits shifted out.
    - Register the shifted field, sticky_partial and d[2:0].
  - Stage 2 (fine):
    - Shift right by d[2:0]; sticky_new = sticky_partial | OR of the bits shifted out.
    - sig_b_o = {shifted[26:1], shifted[0] | sticky_new}.
- Boundaries:
  - d = 0: sig_b_o = {sig_b_i, 3'b000}.
  - 27 <= d <= 255: sig_b_o[26:1] = 0; sig_b_o[0] = |sig_b_i.
  - sig_b_i = 0: sig_b_o = 0 for every d.
  - Stall: while out_valid_o && !out_ready_i, all out_* hold stable. A full pipe (s1 and s2 valid) deasserts in_ready_o; no data is dropped or duplicated.
  - Simultaneous input, advance and output transfer in the same cycle is legal and sustains full rate.
  - Reset mid-operation: in-flight ops are discarded; out_valid_o = 0 in the cycle after rst_i is sampled high.

Optional Feature:
- Macro FP_ALIGN_FLUSH_EN adds input flush_i (1 bit).
- Defined: flush_i = 1 on a clock edge clears s1_valid and s2_valid, like reset, but data registers are not cleared. An input transfer in the same cycle is dropped. in_ready_o is unaffected.
- Undefined: no flush_i port; only rst_i clears the pipeline.

Test Plan:
- Basic: sig_b = 24'h800000, d = 1, out_ready = 1 -> after 2 cycles sig_b_o = 27'h2000000, sig_a_o and tag_o equal the inputs.
- Sticky: sig_b = 24'hC00001, d = 5 -> sig_b_o = {5'b0, 22'b1100000000000000000000} with bit 0 = 1 (sticky from the shifted-out LSB).
- Saturation: sig_b = 24'h000001, d = 27, 31, 32 and 200 -> sig_b_o = 27'h0000001 each time; sig_b = 0, d = 200 -> 0.
- Backpressure: stream 6 ops with tags 0-5, hold out_ready = 0 for 4 cycles mid-stream -> in_ready_o = 0 once 2 ops are buffered, outputs stable while stalled, tags exit in order 0-5 with no loss.
- Full rate: 10 back-to-back ops with out_ready = 1 -> 10 outputs on consecutive cycles starting 2 cycles after the first input.
- Reset/flush: assert rst_i (and, with FP_ALIGN_FLUSH_EN, flush_i) with 2 ops in flight -> out_valid_o = 0 next cycle, next accepted op emerges with correct data.

Source files
------------

// File: rtl/fp_align_shift.sv
// Two-stage alignment shifter: right-shifts B into a {sig, guard, round, sticky}
// field with valid/ready backpressure. Optional FP_ALIGN_FLUSH_EN adds flush_i.
module fp_align_shift #(
   parameter int TAG_W = 4,
   parameter int EXP_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
`ifdef FP_ALIGN_FLUSH_EN
   input  logic             flush_i,
`endif
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [23:0]      sig_a_i,
   input  logic [23:0]      sig_b_i,
   input  logic [EXP_W-1:0] exp_diff_i,
   input  logic [EXP_W-1:0] exp_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [23:0]      sig_a_o,
   output logic [26:0]      sig_b_o,
   output logic [EXP_W-1:0] exp_o,
   output logic [TAG_W-1:0] tag_o
);

   logic flush;
`ifdef FP_ALIGN_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   logic             s1_valid_q, s1_valid_d;
   logic [26:0]      s1_field_q, s1_field_d;
   logic             s1_sticky_q, s1_sticky_d;
   logic [2:0]       s1_fine_q, s1_fine_d;
   logic [23:0]      s1_a_q, s1_a_d;
   logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             s2_valid_q, s2_valid_d;
   logic [26:0]      s2_b_q, s2_b_d;
   logic [23:0]      s2_a_q, s2_a_d;
   logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

   logic        s2_load;
   logic        in_ready;
   logic [26:0] ext;
   logic        sat;
   logic [4:0]  c_sh;
   logic [26:0] c_mask;
   logic [26:0] c_field;
   logic        c_sticky;
   logic [26:0] f_mask;
   logic [26:0] f_sh;
   logic        f_sticky;
   logic [26:0] f_res;

   // Coarse shift: multiples of 8, anything >= 32 collapses into sticky
   always_comb begin
      ext      = {sig_b_i, 3'b000};
      sat      = |exp_diff_i[EXP_W-1:5];
      c_sh     = {exp_diff_i[4:3], 3'b000};
      c_mask   = (27'd1 << c_sh) - 27'd1;
      c_field  = ext >> c_sh;
      c_sticky = |(ext & c_mask);
      if (sat) begin
         c_field  = '0;
         c_sticky = |sig_b_i;
      end
   end

   always_comb begin
      f_mask   = (27'd1 << s1_fine_q) - 27'd1;
      f_sh     = s1_field_q >> s1_fine_q;
      f_sticky = s1_sticky_q | (|(s1_field_q & f_mask));
      f_res    = {f_sh[26:1], f_sh[0] | f_sticky};
   end

   always_comb begin
      s2_load     = !s2_valid_q || out_ready_i;
      in_ready    = !s1_valid_q || s2_load;
      s1_valid_d  = s1_valid_q;
      s1_field_d  = s1_field_q;
      s1_sticky_d = s1_sticky_q;
      s1_fine_d   = s1_fine_q;
      s1_a_d      = s1_a_q;
      s1_exp_d    = s1_exp_q;
      s1_tag_d    = s1_tag_q;
      s2_valid_d  = s2_valid_q;
      s2_b_d      = s2_b_q;
      s2_a_d      = s2_a_q;
      s2_exp_d    = s2_exp_q;
      s2_tag_d    = s2_tag_q;
      if (in_ready) begin
         s1_valid_d = in_valid_i;
         if (in_valid_i) begin
            s1_field_d  = c_field;
            s1_sticky_d = c_sticky;
            s1_fine_d   = exp_diff_i[2:0];
            s1_a_d      = sig_a_i;
            s1_exp_d    = exp_i;
            s1_tag_d    = tag_i;
         end
      end
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_b_d   = f_res;
            s2_a_d   = s1_a_q;
            s2_exp_d = s1_exp_q;
            s2_tag_d = s1_tag_q;
         end
      end
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q  <= 1'b0;
         s1_field_q  <= '0;
         s1_sticky_q <= 1'b0;
         s1_fine_q   <= '0;
         s1_a_q      <= '0;
         s1_exp_q    <= '0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_b_q      <= '0;
         s2_a_q      <= '0;
         s2_exp_q    <= '0;
         s2_tag_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_field_q  <= s1_field_d;
         s1_sticky_q <= s1_sticky_d;
         s1_fine_q   <= s1_fine_d;
         s1_a_q      <= s1_a_d;
         s1_exp_q    <= s1_exp_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         s2_b_q      <= s2_b_d;
         s2_a_q      <= s2_a_d;
         s2_exp_q    <= s2_exp_d;
         s2_tag_q    <= s2_tag_d;
      end
   end

   assign in_ready_o  = in_ready;
   assign out_valid_o = s2_valid_q;
   assign sig_a_o     = s2_a_q;
   assign sig_b_o     = s2_b_q;
   assign exp_o       = s2_exp_q;
   assign tag_o       = s2_tag_q;

endmodule

// File: tb/tb_fp_align_shift.sv
// Scoreboard bench for fp_align_shift: directed vectors, backpressure,
// full rate and reset (plus flush when FP_ALIGN_FLUSH_EN is defined).
module tb_fp_align_shift;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
`ifdef FP_ALIGN_FLUSH_EN
   logic        flush_i = 1'b0;
`endif
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [23:0] sig_a_i = '0;
   logic [23:0] sig_b_i = '0;
   logic [7:0]  exp_diff_i = '0;
   logic [7:0]  exp_i = '0;
   logic [3:0]  tag_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [23:0] sig_a_o;
   logic [26:0] sig_b_o;
   logic [7:0]  exp_o;
   logic [3:0]  tag_o;

   fp_align_shift #(.TAG_W(4), .EXP_W(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
`ifdef FP_ALIGN_FLUSH_EN
      .flush_i     (flush_i),
`endif
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .sig_a_i     (sig_a_i),
      .sig_b_i     (sig_b_i),
      .exp_diff_i  (exp_diff_i),
      .exp_i       (exp_i),
      .tag_i       (tag_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .sig_a_o     (sig_a_o),
      .sig_b_o     (sig_b_o),
      .exp_o       (exp_o),
      .tag_o       (tag_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] a;
      logic [26:0] b;
      logic [7:0]  e;
      logic [3:0]  t;
   } exp_t;

   exp_t sb[$];
   int   out_cyc[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   rcv = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, act, req);
      end
   endtask

   // Monitor: compares held outputs while stalled, pops on transfer
   always @(negedge clk) begin
      exp_t e;
      if (!rst_i && out_valid_o) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual_tag=%0h required=none", tag_o);
         end else begin
            e = sb[0];
            chk("out_sig_a", 32'(sig_a_o), 32'(e.a));
            chk("out_sig_b", 32'(sig_b_o), 32'(e.b));
            chk("out_exp", 32'(exp_o), 32'(e.e));
            chk("out_tag", 32'(tag_o), 32'(e.t));
            if (out_ready_i) begin
               e = sb.pop_front();
               rcv++;
               out_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic send(input logic [23:0] a, input logic [23:0] b,
                       input logic [7:0] d, input logic [7:0] e,
                       input logic [3:0] t, input logic [26:0] xb,
                       output int tc);
      sig_a_i    = a;
      sig_b_i    = b;
      exp_diff_i = d;
      exp_i      = e;
      tag_i      = t;
      in_valid_i = 1'b1;
      tc = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready_o) begin
            sb.push_back('{a: a, b: xb, e: e, t: t});
            tc = cyc;
            break;
         end
      end
      if (tc < 0) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=no_accept required=accept tag=%0h", t);
      end
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic wait_drain(input string n);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      chk(n, 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   localparam int NV = 13;
   logic [23:0] v_b [NV] = '{24'h800000, 24'hC00001, 24'h000001, 24'h000001,
                             24'h000001, 24'h000001, 24'h000000, 24'hABCDEF,
                             24'hFFFFFF, 24'h800000, 24'h123456, 24'h000001,
                             24'hFFFFFF};
   logic [7:0]  v_d [NV] = '{8'd1, 8'd5, 8'd27, 8'd31, 8'd32, 8'd200, 8'd200,
                             8'd0, 8'd8, 8'd26, 8'd16, 8'd4, 8'd255};
   logic [26:0] v_x [NV] = '{27'h2000000, 27'h0300001, 27'h0000001, 27'h0000001,
                             27'h0000001, 27'h0000001, 27'h0000000, 27'h55E6F78,
                             27'h007FFFF, 27'h0000001, 27'h0000091, 27'h0000001,
                             27'h0000001};

   initial begin
      int tc;
      int c0;
      int r0;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_sig_b", 32'(sig_b_o), 32'd0);
      chk("rst_tag", 32'(tag_o), 32'd0);
      chk("rst_in_ready", 32'(in_ready_o), 32'd1);
      @(posedge clk);
      #1;

      // Directed arithmetic vectors
      for (int i = 0; i < NV; i++)
         send(24'h400000 + 24'(i), v_b[i], v_d[i], 8'(8'h40 + i), 4'(i), v_x[i], tc);
      wait_drain("vec_drain");

      // Backpressure: 4 stalled edges mid-stream
      r0 = rcv;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(24'hA00000 + 24'(i), 24'h800000, 8'(i), 8'h10 + 8'(i), 4'(i),
                    27'h4000000 >> i, tc);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            out_ready_i = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready_o), 32'd0);
            chk("bp_out_valid", 32'(out_valid_o), 32'd1);
            @(posedge clk);
            #1;
            out_ready_i = 1'b1;
         end
      join
      wait_drain("bp_drain");
      chk("bp_count", 32'(rcv - r0), 32'd6);

      // Full rate: outputs on consecutive cycles, 2 after first input
      out_cyc.delete();
      c0 = 0;
      for (int i = 0; i < 10; i++) begin
         send(24'hB00000 + 24'(i), 24'h800000, 8'(i), 8'h20 + 8'(i), 4'(i),
              27'h4000000 >> i, tc);
         if (i == 0) c0 = tc;
      end
      wait_drain("fr_drain");
      chk("fr_count", 32'(out_cyc.size()), 32'd10);
      for (int i = 0; i < out_cyc.size(); i++)
         chk("fr_cycle", 32'(out_cyc[i]), 32'(c0 + 2 + i));

      // Reset with two ops in flight
      out_ready_i = 1'b0;
      send(24'hC00000, 24'h800000, 8'd1, 8'h33, 4'h8, 27'h2000000, tc);
      send(24'hC00001, 24'h800000, 8'd2, 8'h34, 4'h9, 27'h1000000, tc);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_mid_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_mid_sig_b", 32'(sig_b_o), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      out_ready_i = 1'b1;
      send(24'hD00000, 24'hC00001, 8'd5, 8'h55, 4'hA, 27'h0300001, tc);
      wait_drain("rst_after_drain");

`ifdef FP_ALIGN_FLUSH_EN
      out_ready_i = 1'b0;
      send(24'hE00000, 24'h800000, 8'd1, 8'h66, 4'hB, 27'h2000000, tc);
      send(24'hE00001, 24'h800000, 8'd2, 8'h67, 4'hC, 27'h1000000, tc);
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid_o), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      out_ready_i = 1'b1;
      send(24'hE00002, 24'hFFFFFF, 8'd8, 8'h68, 4'hD, 27'h007FFFF, tc);
      wait_drain("flush_after_drain");
`endif

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
